// File: rtl/enigma_pkg.sv
// enigma_pkg: shared letter type, alphabet size and stepper state encoding
package enigma_pkg;
  localparam int NLET = 26;
  typedef logic [4:0] letter_t;
  localparam letter_t LAST = letter_t'(NLET - 1);
  typedef enum logic {IDLE, EMIT} state_t;
  function automatic letter_t legal(input letter_t x);
    return x > LAST ? '0 : x;
  endfunction
endpackage

// File: rtl/rotor_inc.sv
// rotor_inc: combinational rotor position advance, mod NLET, when enabled
module rotor_inc
  import enigma_pkg::*;
(
  input  logic [4:0] pos,
  input  logic       en,
  output logic [4:0] nxt
);
  always_comb nxt = !en ? pos : (pos == LAST ? 5'd0 : pos + 5'd1);
endmodule

// File: rtl/rotor_stepper.sv
// rotor_stepper: accepts keypresses, steps three Enigma rotors with double-step, hands key+positions downstream
module rotor_stepper
  import enigma_pkg::*;
#(
  parameter logic [4:0] R1_NOTCH = 5'd21,
  parameter logic [4:0] R2_NOTCH = 5'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [4:0]  load_r1,
  input  logic [4:0]  load_r2,
  input  logic [4:0]  load_r3,
  input  logic        key_valid,
  input  logic [4:0]  key_in,
  output logic        key_ready,
  output logic [4:0]  data_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  r1_pos,
  output logic [4:0]  r2_pos,
  output logic [4:0]  r3_pos,
  output logic [15:0] key_count
);
  state_t state_q, state_d;
  letter_t r1_q, r1_d, r2_q, r2_d, r3_q, r3_d, data_q, data_d, r1_i, r2_i, r3_i;
  logic [15:0] cnt_q, cnt_d;
  logic accept, dbl, c1;
  assign dbl = r2_q == R2_NOTCH;
  assign c1 = r1_q == R1_NOTCH;
  rotor_inc u_inc1 (.pos(r1_q), .en(1'b1), .nxt(r1_i));
  rotor_inc u_inc2 (.pos(r2_q), .en(c1 || dbl), .nxt(r2_i));
  rotor_inc u_inc3 (.pos(r3_q), .en(dbl), .nxt(r3_i));
  assign key_ready = state_q == IDLE && !load;
  assign accept = key_valid && key_ready && key_in <= LAST;
  always_comb begin
    state_d = state_q;
    r1_d = r1_q;
    r2_d = r2_q;
    r3_d = r3_q;
    data_d = data_q;
    cnt_d = cnt_q;
    if (load) begin
      state_d = IDLE;
      r1_d = legal(load_r1);
      r2_d = legal(load_r2);
      r3_d = legal(load_r3);
      cnt_d = '0;
    end else if (accept) begin
      state_d = EMIT;
      r1_d = r1_i;
      r2_d = r2_i;
      r3_d = r3_i;
      data_d = key_in;
      cnt_d = cnt_q + 16'd1;
    end else if (state_q == EMIT && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
      r3_q <= r3_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_valid = state_q == EMIT;
  assign data_out = data_q;
  assign r1_pos = r1_q;
  assign r2_pos = r2_q;
  assign r3_pos = r3_q;
  assign key_count = cnt_q;
endmodule

// File: tb/tb_rotor_stepper.sv
// tb_rotor_stepper: directed + random scoreboard bench against an arithmetic Enigma stepping model
module tb_rotor_stepper;
  logic clk = 0, rst = 1, load = 0, key_valid = 0, out_ready = 0;
  logic [4:0] load_r1 = 0, load_r2 = 0, load_r3 = 0, key_in = 0;
  logic key_ready, out_valid;
  logic [4:0] data_out, r1_pos, r2_pos, r3_pos;
  logic [15:0] key_count;
  typedef struct packed {logic [4:0] d, a, b, c; logic [15:0] n;} exp_t;
  exp_t q[$];
  int compared = 0, failed = 0;
  int m1, m2, m3, mc;
  bit rand_rdy = 0;

  rotor_stepper dut (
    .clk(clk), .rst(rst), .load(load), .load_r1(load_r1), .load_r2(load_r2), .load_r3(load_r3),
    .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready), .data_out(data_out),
    .out_valid(out_valid), .out_ready(out_ready), .r1_pos(r1_pos), .r2_pos(r2_pos),
    .r3_pos(r3_pos), .key_count(key_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_pos(input string name, input int a, input int b, input int c);
    check(name, {17'd0, r1_pos, r2_pos, r3_pos}, {17'd0, 5'(a), 5'(b), 5'(c)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic model_reset(input int a, input int b, input int c);
    m1 = a > 25 ? 0 : a;
    m2 = b > 25 ? 0 : b;
    m3 = c > 25 ? 0 : c;
    mc = 0;
    q.delete();
  endtask

  task automatic model_step(input int k);
    bit d, c1;
    d = m2 == 4;
    c1 = m1 == 21;
    m1 = (m1 + 1) % 26;
    if (c1 || d) m2 = (m2 + 1) % 26;
    if (d) m3 = (m3 + 1) % 26;
    mc = (mc + 1) % 65536;
    q.push_back({5'(k), 5'(m1), 5'(m2), 5'(m3), 16'(mc)});
  endtask

  task automatic send(input int k);
    int n = 0;
    while (!key_ready && n < 100) begin
      tick();
      n++;
    end
    if (!key_ready) check("ready_timeout", {31'd0, key_ready}, 32'd1);
    key_valid = 1;
    key_in = 5'(k);
    if (key_ready && k < 26) model_step(k);
    tick();
    key_valid = 0;
  endtask

  task automatic do_load(input int a, input int b, input int c);
    load = 1;
    load_r1 = 5'(a);
    load_r2 = 5'(b);
    load_r3 = 5'(c);
    tick();
    load = 0;
    model_reset(a, b, c);
  endtask

  task automatic do_rst();
    rst = 1;
    tick();
    rst = 0;
    model_reset(0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_out", {27'd0, data_out}, 32'hffffffff);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out", {1'b0, data_out, r1_pos, r2_pos, r3_pos, key_count}, {1'b0, e});
      end
    end
  end

  initial begin
    tick();
    tick();
    rst = 0;
    model_reset(0, 0, 0);
    check_pos("rst_pos", 0, 0, 0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, key_ready}, 32'd1);
    check("rst_count", {16'd0, key_count}, 32'd0);
    check("rst_data", {27'd0, data_out}, 32'd0);

    do_load(0, 0, 0);
    send(7);
    check("t2_valid", {31'd0, out_valid}, 32'd1);
    check("t2_data", {27'd0, data_out}, 32'd7);
    check_pos("t2_pos", 1, 0, 0);
    out_ready = 1;
    tick();
    check("t2_idle", {31'd0, out_valid}, 32'd0);
    do_load(25, 0, 0);
    send(9);
    check_pos("t2_wrap", 0, 0, 0);

    do_load(20, 3, 0);
    send(1);
    check_pos("t3_k1", 21, 3, 0);
    send(2);
    check_pos("t3_k2", 22, 4, 0);
    send(3);
    check_pos("t3_k3", 23, 5, 1);
    tick();

    do_load(21, 4, 25);
    send(4);
    check_pos("t4_carry", 22, 5, 0);
    tick();

    do_load(2, 2, 2);
    out_ready = 0;
    send(11);
    for (int i = 0; i < 3; i++) begin
      key_valid = 1;
      key_in = 5;
      check("t5_valid", {31'd0, out_valid}, 32'd1);
      check("t5_ready", {31'd0, key_ready}, 32'd0);
      check("t5_data", {27'd0, data_out}, 32'd11);
      check_pos("t5_pos", 3, 2, 2);
      tick();
    end
    key_valid = 0;
    out_ready = 1;
    tick();
    check("t5_release", {31'd0, out_valid}, 32'd0);
    check("t5_ready1", {31'd0, key_ready}, 32'd1);
    check("t5_count", {16'd0, key_count}, 32'd1);

    send(27);
    check("t6_ill_ready", {31'd0, key_ready}, 32'd1);
    check("t6_ill_valid", {31'd0, out_valid}, 32'd0);
    check_pos("t6_ill_pos", 3, 2, 2);
    check("t6_ill_count", {16'd0, key_count}, 32'd1);

    out_ready = 0;
    send(6);
    check("t6_emit", {31'd0, out_valid}, 32'd1);
    do_load(8, 9, 30);
    check("t6_load_valid", {31'd0, out_valid}, 32'd0);
    check_pos("t6_load_pos", 8, 9, 0);
    check("t6_load_count", {16'd0, key_count}, 32'd0);

    send(12);
    do_rst();
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check_pos("t6_rst_pos", 0, 0, 0);
    check("t6_rst_data", {27'd0, data_out}, 32'd0);
    check("t6_rst_count", {16'd0, key_count}, 32'd0);
    check("t6_rst_ready", {31'd0, key_ready}, 32'd1);

    rand_rdy = 1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 49) == 0)
        do_load(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      send(int'($urandom_range(0, 27)));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_rdy = 0;
    out_ready = 1;
    for (int n = 0; n < 20 && q.size() > 0; n++) tick();
    check("drain", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
